// File: rtl/transformer_pkg.sv
// Constants shared between the triangle loader and the triangle feeder.
`timescale 1ns / 1ps

package transformer_pkg;

    localparam logic [7:0]  TRI_SYNC_BYTE     = 8'hA5;
    localparam int unsigned TRI_WORDS_DEFAULT = 10;

endpackage

// File: rtl/triangle_loader.sv
// Parses host-link packets (sync, count, payload, checksum) into 32-bit triangle-memory writes
// and publishes the committed triangle count once the checksum matches.
`timescale 1ns / 1ps

module triangle_loader
    import transformer_pkg::*;
#(
    parameter int unsigned MAX_TRIS  = 430,
    parameter int unsigned TRI_WORDS = TRI_WORDS_DEFAULT,
    parameter int unsigned ADDR_W    = $clog2(MAX_TRIS * TRI_WORDS)
) (
    input  logic              clk_render,
    input  logic              rst_render,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              hold,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       tri_count,
    output logic              busy,
    output logic              load_done,
    output logic              load_error
);

    typedef enum logic [2:0] {
        StIdle,
        StCntLo,
        StCntHi,
        StPayload,
        StCheck
    } state_e;

    state_e            state_q;
    logic              rdy_q;
    logic [15:0]       count_q;
    logic [ADDR_W-1:0] word_q;
    logic [ADDR_W-1:0] last_q;
    logic [1:0]        byte_q;
    logic [23:0]       asm_q;
    logic [7:0]        xor_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic [15:0]       tri_count_q;
    logic              load_done_q;
    logic              load_error_q;

    logic        accept;
    logic [15:0] count_w;
    logic [31:0] words_w;

    assign accept  = in_valid && in_ready;
    assign count_w = {in_data, count_q[7:0]};
    assign words_w = 32'(count_w) * TRI_WORDS;

    // rdy_q holds in_ready low through reset and for the first cycle after release.
    assign in_ready   = rdy_q && !(state_q == StPayload && hold);
    assign busy       = (state_q != StIdle);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign tri_count  = tri_count_q;
    assign load_done  = load_done_q;
    assign load_error = load_error_q;

    always_ff @(posedge clk_render or posedge rst_render) begin
        if (rst_render) begin
            state_q      <= StIdle;
            rdy_q        <= 1'b0;
            count_q      <= '0;
            word_q       <= '0;
            last_q       <= '0;
            byte_q       <= '0;
            asm_q        <= '0;
            xor_q        <= '0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            tri_count_q  <= '0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
        end else begin
            rdy_q        <= 1'b1;
            mem_we_q     <= 1'b0;
            load_done_q  <= 1'b0;
            load_error_q <= 1'b0;
            if (accept) begin
                unique case (state_q)
                    StIdle: begin
                        if (in_data == TRI_SYNC_BYTE) state_q <= StCntLo;
                    end
                    StCntLo: begin
                        count_q <= {8'h00, in_data};
                        word_q  <= '0;
                        byte_q  <= '0;
                        xor_q   <= '0;
                        state_q <= StCntHi;
                    end
                    StCntHi: begin
                        count_q <= count_w;
                        last_q  <= ADDR_W'(words_w - 32'd1);
                        word_q  <= '0;
                        byte_q  <= '0;
                        xor_q   <= '0;
                        if (32'(count_w) > MAX_TRIS) begin
                            load_error_q <= 1'b1;
                            state_q      <= StIdle;
                        end else if (count_w == 16'd0) begin
                            state_q <= StCheck;
                        end else begin
                            state_q <= StPayload;
                        end
                    end
                    StPayload: begin
                        xor_q  <= xor_q ^ in_data;
                        byte_q <= byte_q + 2'd1;
                        case (byte_q)
                            2'd0: asm_q[7:0]   <= in_data;
                            2'd1: asm_q[15:8]  <= in_data;
                            2'd2: asm_q[23:16] <= in_data;
                            default: begin
                                mem_we_q    <= 1'b1;
                                mem_addr_q  <= word_q;
                                mem_wdata_q <= {in_data, asm_q};
                                word_q      <= word_q + ADDR_W'(1);
                                if (word_q == last_q) state_q <= StCheck;
                            end
                        endcase
                    end
                    StCheck: begin
                        if (in_data == xor_q) begin
                            tri_count_q <= count_q;
                            load_done_q <= 1'b1;
                        end else begin
                            load_error_q <= 1'b1;
                        end
                        state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: doc/triangle_loader.md
TRIANGLE_LOADER -- requirements
Module: triangle_loader

Interface
REQ-001 SHALL have parameter MAX_TRIS, default 430, meaning the triangle memory capacity in triangles.
REQ-002 SHALL have parameter TRI_WORDS, default 10, meaning 32-bit words per triangle record: 9 q16_16 vertex coordinates plus 1 colour word.
REQ-003 SHALL have parameter ADDR_W, default $clog2(MAX_TRIS*TRI_WORDS), meaning the memory word-address width.
REQ-004 clk_render  in  1  clock; all logic is in this single domain.
REQ-005 rst_render  in  1  reset; asynchronous, active-high.
REQ-006 in_data  in  8  byte from the host link, already synchronous to clk_render.
REQ-007 in_valid  in  1  in_data is valid this cycle.
REQ-008 in_ready  out  1  the loader accepts in_data this cycle; a byte transfers when in_valid and in_ready are both high.
REQ-009 hold  in  1  renderer is reading triangle memory (feeder busy); stalls payload intake.
REQ-010 mem_we  out  1  triangle-memory write strobe.
REQ-011 mem_addr  out  ADDR_W  word address of the write.
REQ-012 mem_wdata  out  32  write data.
REQ-013 tri_count  out  16  committed triangle count for the feeder.
REQ-014 busy  out  1  high in every state except IDLE.
REQ-015 load_done  out  1  one-cycle pulse on successful commit.
REQ-016 load_error  out  1  one-cycle pulse on an aborted load.

Function
REQ-017 Packet format SHALL be: sync byte 0xA5; COUNT as 16-bit little-endian (lo, hi); COUNT*TRI_WORDS*4 payload bytes; one checksum byte equal to the XOR of all payload bytes.
REQ-018 FSM states SHALL be IDLE, CNT_LO, CNT_HI, PAYLOAD, CHECK.
REQ-019 IDLE: in_ready=1; byte 0xA5 -> CNT_LO; any other byte is discarded and the FSM stays in IDLE.
REQ-020 CNT_LO/CNT_HI: in_ready=1; the FSM latches COUNT and clears the word address, byte index and running XOR.
REQ-021 After CNT_HI: COUNT > MAX_TRIS -> load_error pulse, return to IDLE; COUNT = 0 -> CHECK; otherwise -> PAYLOAD.
REQ-022 PAYLOAD: in_ready = !hold.
- Bytes assemble little-endian into a 32-bit word; byte 0 goes to bits [7:0].
- Every accepted byte is XORed into the running checksum.
REQ-023 On acceptance of the 4th byte of a word, mem_we SHALL be high on the next cycle with that word and its address, then the address increments.
- Write addresses start at 0 and are contiguous.
- mem_we is never high for more than one cycle per word.
REQ-024 When the last word (address COUNT*TRI_WORDS-1) is accepted, the FSM SHALL move to CHECK.
REQ-025 CHECK: in_ready=1.
- Byte equal to the running XOR -> tri_count <= COUNT, load_done pulse, IDLE.
- Otherwise -> tri_count unchanged, load_error pulse, IDLE.
REQ-026 hold SHALL only gate in_ready in PAYLOAD; it SHALL NOT suppress a pending mem_we already scheduled by REQ-023.
REQ-027 mem_addr SHALL never exceed MAX_TRIS*TRI_WORDS-1.
REQ-028 Memory written by an aborted load SHALL be left as written; only tri_count gates feeder visibility.
REQ-029 load_done and load_error SHALL never be high in the same cycle.

Reset
REQ-030 On reset SHALL be: state IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, tri_count=0, busy=0, load_done=0, load_error=0, with all internal counters and the running XOR cleared.
REQ-031 in_ready SHALL go to 1 on the first clock after reset release.
REQ-032 Reset asserted mid-packet SHALL abandon the packet with no commit and no pulse; a partial word SHALL NOT be written.

Structure
REQ-033 TRI_SYNC_BYTE (0xA5) and the default TRI_WORDS SHALL live in transformer_pkg, shared with triangle_feeder.
REQ-034 The FSM enum SHALL be declared local to the module.
REQ-035 The design SHALL be a single module with no sub-modules; the memory itself is external.

Verification
REQ-036 Reset, then 0xA5, 0x01, 0x00, 40 bytes 0x00..0x27, checksum = XOR of 0x00..0x27 -> 10 writes to addresses 0..9, word 0 = 0x03020100; tri_count=1; one load_done pulse.
REQ-037 Same packet with the checksum byte inverted -> 10 writes occur; tri_count stays 0; one load_error pulse.
REQ-038 Bytes 0x00, 0x13, then 0xA5, 0x00, 0x00, 0x00 -> the first two bytes are ignored; tri_count=0; load_done pulse; no mem_we.
REQ-039 COUNT=431 (0xAF, 0x01) -> load_error immediately after CNT_HI; FSM back in IDLE; no mem_we.
REQ-040 hold=1 for 20 cycles mid-PAYLOAD with in_valid held high -> in_ready=0 throughout; no byte is lost; final data and tri_count are correct.
REQ-041 rst_render pulsed after 18 payload bytes, then a valid 1-triangle packet -> no commit from the first packet; the second packet commits tri_count=1 with addresses restarting at 0.
